frame_feeder: RTL
=================

# frame_feeder

Upstream feeder between the input word FIFO and the classifier core (`top`). Once the core reports its weights are loaded, it pulls exactly one 784-pixel binary frame (25 × 32-bit words) from the FIFO per classification. It drives `input_valid`/`sof`/`eof` to the core, zero-masks the padding bits of the last word, and holds off the next frame until the core returns its result.

## Interface
- `DATA_W`, 32, FIFO/core word width
- `WORDS_PER_FRAME`, 25, words per frame
- `LAST_BITS`, 16, valid MSBs in final word (784 − 24·32)
- `CNT_W`, 16, frame counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fifo_dout`  in  DATA_W  FIFO read data, valid the cycle after `fifo_rd_en`
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_en`  out  1  FIFO read strobe
- `load_weight_done`  in  1  core weight load complete (level)
- `result_valid`  in  1  core `output_valid` pulse; frame consumed
- `core_d_in`  out  DATA_W  registered word to core
- `core_input_valid`  out  1  word strobe
- `core_sof`  out  1  with first word of frame
- `core_eof`  out  1  with last word of frame
- `busy`  out  1  state ≠ IDLE
- `frames_done`  out  CNT_W  completed frames (wraps)

## Operation
- States: IDLE, FEED, DRAIN, WAIT_RES.
- IDLE: wait for `load_weight_done`=1, then go to FEED. `load_weight_done` is sampled only in IDLE. Deassertion later is ignored.
- FEED: `fifo_rd_en` = !`fifo_empty` (combinational, gated by state). Each read increments `rd_cnt` (0..WORDS_PER_FRAME−1). The read with `rd_cnt`=WORDS_PER_FRAME−1 moves to DRAIN. Reads never exceed WORDS_PER_FRAME per frame.
- DRAIN: one cycle, for the last word to propagate, then go to WAIT_RES.
- WAIT_RES: no reads. On `result_valid`, increment `frames_done`, clear counters, return to FEED (not IDLE).
- Output path:
  - `rd_q` = registered `fifo_rd_en`. When `rd_q`=1, register `fifo_dout` into `core_d_in` and assert `core_input_valid` for one cycle.
  - `out_cnt` counts emitted words.
  - `core_sof` = valid && `out_cnt`==0.
  - `core_eof` = valid && `out_cnt`==WORDS_PER_FRAME−1.
  - On eof, `core_d_in[DATA_W−1−LAST_BITS:0]` is forced to 0 (bits MSB-first). If LAST_BITS==DATA_W, no masking.
- `result_valid` outside WAIT_RES is ignored (no count, no state change).
- `frames_done` wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (async assert, sync deassert expected): state IDLE. `fifo_rd_en`, `core_input_valid`, `core_sof`, `core_eof`, `busy` = 0. `core_d_in`, `frames_done`, `rd_cnt`, `out_cnt`, `rd_q` = 0.
- Reset mid-frame: the partial frame is abandoned. The FIFO is not flushed. Words already read are lost. Next run restarts with sof.
- Latency:
  - `fifo_rd_en` at cycle N: `fifo_dout` valid at N+1; `core_input_valid` and `core_d_in` at N+2.
  - Back-to-back reads give back-to-back valids. Bubbles on empty pass through as valid=0 gaps.
- IDLE→FEED: `fifo_rd_en` can assert the cycle after `load_weight_done` is seen.
- WAIT_RES→FEED on `result_valid` at cycle M: first read at M+1 if the FIFO is non-empty.
- `fifo_empty` is re-evaluated every cycle. No read is issued while empty.

## Structure
- Shared package `feeder_pkg`: state enum `feed_state_t`, constants `FRAME_BITS`=784, `WORDS_PER_FRAME`, `LAST_BITS` derivation, `last_word_mask()` function.
- Single module. No sub-module needed; the output register stage stays inline.

## Test plan
- Reset, `load_weight_done`=0, FIFO holds 30 words → no `fifo_rd_en` and no valid for 20 cycles; all outputs 0.
- `load_weight_done`=1, FIFO non-empty, words 0x00000001..0x00000019 → exactly 25 reads. First valid at +2 cycles with `core_sof`=1, data 0x1. Last valid has `core_eof`=1, data 0x00000019 masked to 0x00000000. Last word 0xFFFFFFFF → 0xFFFF0000.
- Random `fifo_empty` toggling with 50% duty → valids carry gaps, still exactly 25 per frame, order preserved, single sof and single eof.
- In WAIT_RES, FIFO holds 10 extra words, `result_valid` held 0 for 100 cycles → zero reads. Then pulse `result_valid` → `frames_done`=1, next read on the following cycle, new sof.
- `result_valid` pulsed during FEED → `frames_done` unchanged, frame completes normally.
- Assert `rst`=0 after 12 words of a frame → outputs clear immediately. After release and `load_weight_done`, next emitted word carries `core_sof`=1 and is FIFO word 13.

Source files
------------

// File: rtl/feeder_pkg.sv
// feeder_pkg: frame geometry, FSM state type and last-word mask helper shared by frame_feeder.
package feeder_pkg;
    localparam int FRAME_BITS      = 784;
    localparam int DATA_W          = 32;
    localparam int WORDS_PER_FRAME = (FRAME_BITS + DATA_W - 1) / DATA_W;
    localparam int LAST_BITS       = FRAME_BITS - (WORDS_PER_FRAME - 1) * DATA_W;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, WAIT_RES} feed_state_t;

    // Keeps the top last_bits bits of a word; a full word yields all ones.
    function automatic logic [DATA_W-1:0] last_word_mask(input int last_bits);
        return ~({DATA_W{1'b1}} >> last_bits);
    endfunction
endpackage

// File: rtl/frame_feeder.sv
// frame_feeder: pulls one frame of words from the FIFO per classification and
// streams it to the core with sof/eof framing and last-word padding masked off.
module frame_feeder #(
    parameter int DATA_W          = feeder_pkg::DATA_W,
    parameter int WORDS_PER_FRAME = feeder_pkg::WORDS_PER_FRAME,
    parameter int LAST_BITS       = feeder_pkg::LAST_BITS,
    parameter int CNT_W           = feeder_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              load_weight_done,
    input  logic              result_valid,
    output logic [DATA_W-1:0] core_d_in,
    output logic              core_input_valid,
    output logic              core_sof,
    output logic              core_eof,
    output logic              busy,
    output logic [CNT_W-1:0]  frames_done
);
    import feeder_pkg::*;

    localparam int                IW       = $clog2(WORDS_PER_FRAME + 1);
    localparam logic [IW-1:0]     LAST_IDX = IW'(WORDS_PER_FRAME - 1);
    localparam logic [DATA_W-1:0] MASK     = ~({DATA_W{1'b1}} >> LAST_BITS);

    feed_state_t   r_state, w_next;
    logic [IW-1:0] r_rd_cnt, r_out_cnt;
    logic          r_rd_q;
    logic          w_res, w_last_out;

    assign fifo_rd_en = (r_state == FEED) && !fifo_empty;
    assign busy       = (r_state != IDLE);
    assign w_res      = (r_state == WAIT_RES) && result_valid;
    assign w_last_out = (r_out_cnt == LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = load_weight_done ? FEED : IDLE;
            FEED:     w_next = (fifo_rd_en && r_rd_cnt == LAST_IDX) ? DRAIN : FEED;
            DRAIN:    w_next = WAIT_RES;
            WAIT_RES: w_next = result_valid ? FEED : WAIT_RES;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_rd_cnt         <= '0;
            r_out_cnt        <= '0;
            r_rd_q           <= 1'b0;
            core_d_in        <= '0;
            core_input_valid <= 1'b0;
            core_sof         <= 1'b0;
            core_eof         <= 1'b0;
            frames_done      <= '0;
        end else begin
            r_state          <= w_next;
            r_rd_q           <= fifo_rd_en;
            core_input_valid <= r_rd_q;
            core_sof         <= r_rd_q && (r_out_cnt == '0);
            core_eof         <= r_rd_q && w_last_out;
            if (w_res)
                r_rd_cnt <= '0;
            else if (fifo_rd_en)
                r_rd_cnt <= (r_rd_cnt == LAST_IDX) ? '0 : r_rd_cnt + 1'b1;
            if (w_res)
                r_out_cnt <= '0;
            else if (r_rd_q)
                r_out_cnt <= w_last_out ? '0 : r_out_cnt + 1'b1;
            if (r_rd_q)
                core_d_in <= w_last_out ? (fifo_dout & MASK) : fifo_dout;
            if (w_res)
                frames_done <= frames_done + 1'b1;
        end
    end
endmodule
